// File: rtl/spi_rd_burst_ctrl_if.sv
// Bundle of the burst-control, SPI-master and output-stream signals of spi_rd_burst_ctrl.
//   slave  : view taken by spi_rd_burst_ctrl itself
//   master : view taken by the surrounding logic (burst requester, SPI master, consumer)
// Signals:
//   burst_start/burst_len -> burst request; busy/burst_done <- burst status
//   spi_sclk_divider/spi_rd_en/spi_tx_wr_data -> SPI master; spi_rd_done/spi_rd_data <- SPI master
//   m_data/m_valid -> consumer; m_ready <- consumer; fifo_level/err -> status
interface spi_rd_burst_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic          burst_start;
    logic [7:0]    burst_len;
    logic          busy;
    logic          burst_done;
    logic [7:0]    spi_sclk_divider;
    logic          spi_rd_en;
    logic [7:0]    spi_tx_wr_data;
    logic          spi_rd_done;
    logic [7:0]    spi_rd_data;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] fifo_level;
    logic          err;

    modport slave (
        input  burst_start, burst_len, spi_rd_done, spi_rd_data, m_ready,
        output busy, burst_done, spi_sclk_divider, spi_rd_en, spi_tx_wr_data,
        output m_data, m_valid, fifo_level, err
    );

    modport master (
        output burst_start, burst_len, spi_rd_done, spi_rd_data, m_ready,
        input  busy, burst_done, spi_sclk_divider, spi_rd_en, spi_tx_wr_data,
        input  m_data, m_valid, fifo_level, err
    );
endinterface

// File: rtl/spi_rd_burst_ctrl.sv
// Burst sequencer and receive FIFO for the SPI receive master.
// Accepts a burst of burst_len bytes, issues one spi_rd_en window per byte with a
// chip-select recovery gap between bytes, stores received bytes in a first-word-fall-through
// FIFO and presents them on a valid/ready stream. Reads pause while the FIFO is full.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   ctrl_io : burst request/status, SPI master handshake and output stream (slave view)
module spi_rd_burst_ctrl #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 10,
    parameter logic [7:0]  SCLK_DIV   = 8'd1,
    parameter logic [7:0]  DUMMY_TX   = 8'h00
) (
    input logic                clk,
    input logic                rst,
    spi_rd_burst_ctrl_if.slave ctrl_io
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StRead = 3'd2;
    localparam logic [2:0] StGap  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rd_en_q, rd_en_d;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_ptr_nxt;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    m_data_q, m_data_d;

    logic full;
    logic push;
    logic pop;

    assign full       = (count_q == LW'(DEPTH));
    assign pop        = (count_q != '0) && ctrl_io.m_ready;
    assign rd_ptr_nxt = rd_ptr_q + PW'(1);

    // Burst sequencer
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        push    = 1'b0;

        case (state_q)
            StIdle: begin
                if (ctrl_io.burst_start) begin
                    busy_d = 1'b1;
                    if (ctrl_io.burst_len == 8'd0) begin
                        state_d = StDone;
                    end else begin
                        rem_d   = ctrl_io.burst_len;
                        state_d = full ? StWait : StRead;
                    end
                end
            end
            StWait: begin
                if (!full) state_d = StRead;
            end
            StRead: begin
                if (ctrl_io.spi_rd_done) begin
                    // The handshake completes even if the byte has to be dropped.
                    push    = !full;
                    rem_d   = rem_q - 8'd1;
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = StGap;
                end
            end
            StGap: begin
                // Exit on the cycle the counter is already 0: GAP_CYCLES+1 low cycles.
                if (gap_q == '0) begin
                    if (rem_q == 8'd0) state_d = StDone;
                    else if (!full)    state_d = StRead;
                    else               state_d = StWait;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (ctrl_io.spi_rd_done && (state_q != StRead)) err_d = 1'b1;
        if (ctrl_io.spi_rd_done && (state_q == StRead) && full) err_d = 1'b1;

        rd_en_d = (state_d == StRead);
    end

    // FIFO bookkeeping; m_data is a registered copy of the head entry
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        m_data_d = m_data_q;
        if (pop) begin
            if (count_q > LW'(1)) m_data_d = mem_q[rd_ptr_nxt];
            else if (push)        m_data_d = ctrl_io.spi_rd_data;
        end else if (push && (count_q == '0)) begin
            m_data_d = ctrl_io.spi_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rem_q    <= 8'd0;
            gap_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            m_data_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd_en_q  <= rd_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            m_data_q <= m_data_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ctrl_io.spi_rd_data;
    end

    assign ctrl_io.busy             = busy_q;
    assign ctrl_io.burst_done       = done_q;
    assign ctrl_io.spi_sclk_divider = SCLK_DIV;
    assign ctrl_io.spi_rd_en        = rd_en_q;
    assign ctrl_io.spi_tx_wr_data   = DUMMY_TX;
    assign ctrl_io.m_data           = m_data_q;
    assign ctrl_io.m_valid          = (count_q != '0);
    assign ctrl_io.fifo_level       = count_q;
    assign ctrl_io.err              = err_q;
endmodule

// File: tb/tb_spi_rd_burst_ctrl.sv
// Bench for spi_rd_burst_ctrl: SPI master model with fixed byte latency, scoreboard of
// received bytes checked on every stream handshake, and a monitor of spi_rd_en windows.
module tb_spi_rd_burst_ctrl;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 10;
    localparam int unsigned LAT   = 3;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [7:0] spi_q[$];
    logic [7:0] exp_q[$];
    bit         spur_req = 1'b0;

    int   win_cnt;
    int   min_low;
    int   low_run;
    int   done_cnt;
    int   pop_cnt;
    logic prev_en;

    spi_rd_burst_ctrl_if #(.DEPTH(DEPTH)) bus ();

    spi_rd_burst_ctrl #(
        .DEPTH     (DEPTH),
        .GAP_CYCLES(GAP),
        .SCLK_DIV  (8'd1),
        .DUMMY_TX  (8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        win_cnt  = 0;
        min_low  = 1000;
        low_run  = 0;
        done_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic start_burst(input logic [7:0] len);
        bus.burst_start = 1'b1;
        bus.burst_len   = len;
        tick(1);
        bus.burst_start = 1'b0;
        bus.burst_len   = 8'd0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done_cnt != 0), 32'd1);
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_q.delete();
        exp_q.delete();
        tick(1);
        rst = 1'b0;
    endtask

    // SPI master model: answers each spi_rd_en window after LAT cycles
    initial begin : spi_model
        int         cnt;
        logic [7:0] b;
        cnt = 0;
        bus.spi_rd_done = 1'b0;
        bus.spi_rd_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.spi_rd_done = 1'b0;
            if (spur_req) begin
                bus.spi_rd_done = 1'b1;
                bus.spi_rd_data = 8'hEE;
                spur_req        = 1'b0;
                cnt             = 0;
            end else if (bus.spi_rd_en) begin
                cnt++;
                if (cnt == LAT) begin
                    b = 8'h00;
                    if (spi_q.size() != 0) b = spi_q.pop_front();
                    bus.spi_rd_data = b;
                    bus.spi_rd_done = 1'b1;
                    exp_q.push_back(b);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Window/gap monitor and scoreboard
    initial begin : monitor
        logic [7:0] e;
        prev_en = 1'b0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (bus.burst_done) done_cnt++;
            if (bus.spi_rd_en) begin
                if (!prev_en) begin
                    if (win_cnt > 0 && low_run < min_low) min_low = low_run;
                    win_cnt++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_en = bus.spi_rd_en;
            if (!rst && bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected", {24'd0, bus.m_data}, 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_data", {24'd0, bus.m_data}, {24'd0, e});
                    pop_cnt++;
                end
            end
        end
    end

    initial begin : main
        int n;
        rst             = 1'b1;
        bus.burst_start = 1'b0;
        bus.burst_len   = 8'd0;
        bus.m_ready     = 1'b0;

        // Reset values
        tick(2);
        @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.burst_done), 32'd0);
        check_eq("rst_rd_en", 32'(bus.spi_rd_en), 32'd0);
        check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
        check_eq("rst_m_data", 32'(bus.m_data), 32'd0);
        check_eq("rst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("sclk_div", 32'(bus.spi_sclk_divider), 32'd1);
        check_eq("tx_data", 32'(bus.spi_tx_wr_data), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Basic burst
        bus.m_ready = 1'b1;
        clear_mon();
        spi_q = '{8'hA5, 8'h3C, 8'hFF};
        start_burst(8'd3);
        wait_done("basic_done_seen");
        tick(3);
        check_eq("basic_windows", 32'(win_cnt), 32'd3);
        check_eq("basic_gap_min", 32'(min_low >= int'(GAP)), 32'd1);
        check_eq("basic_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("basic_pops", 32'(pop_cnt), 32'd3);
        @(negedge clk);
        check_eq("basic_busy", 32'(bus.busy), 32'd0);
        check_eq("basic_err", 32'(bus.err), 32'd0);
        tick(1);

        // Zero length: burst_start in cycle c, busy in c+1, burst_done in c+2
        clear_mon();
        bus.burst_start = 1'b1;
        bus.burst_len   = 8'd0;
        @(negedge clk);
        check_eq("zl_c0_busy", 32'(bus.busy), 32'd0);
        tick(1);
        bus.burst_start = 1'b0;
        @(negedge clk);
        check_eq("zl_c1_busy", 32'(bus.busy), 32'd1);
        check_eq("zl_c1_done", 32'(bus.burst_done), 32'd0);
        tick(1);
        @(negedge clk);
        check_eq("zl_c2_busy", 32'(bus.busy), 32'd0);
        check_eq("zl_c2_done", 32'(bus.burst_done), 32'd1);
        tick(1);
        @(negedge clk);
        check_eq("zl_c3_done", 32'(bus.burst_done), 32'd0);
        tick(1);
        check_eq("zl_windows", 32'(win_cnt), 32'd0);

        // Backpressure
        bus.m_ready = 1'b0;
        clear_mon();
        for (int i = 0; i < 10; i++) spi_q.push_back(8'($urandom_range(0, 255)));
        start_burst(8'd10);
        n = 0;
        @(negedge clk);
        while (bus.fifo_level != 4'(DEPTH) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_full_reached", 32'(bus.fifo_level), DEPTH);
        tick(30);
        @(negedge clk);
        check_eq("bp_level_held", 32'(bus.fifo_level), DEPTH);
        check_eq("bp_rd_en_low", 32'(bus.spi_rd_en), 32'd0);
        check_eq("bp_windows_8", 32'(win_cnt), 32'd8);
        tick(1);
        bus.m_ready = 1'b1;
        wait_done("bp_done_seen");
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        check_eq("bp_windows_10", 32'(win_cnt), 32'd10);
        check_eq("bp_pops", 32'(pop_cnt), 32'd10);
        check_eq("bp_err", 32'(bus.err), 32'd0);

        // burst_start while busy has no effect on the byte count
        clear_mon();
        spi_q = '{8'h10, 8'h20};
        start_burst(8'd2);
        tick(2);
        start_burst(8'd5);
        wait_done("busy_start_done");
        tick(20);
        check_eq("busy_start_windows", 32'(win_cnt), 32'd2);
        check_eq("busy_start_pops", 32'(pop_cnt), 32'd2);
        check_eq("busy_start_done_cnt", 32'(done_cnt), 32'd1);

        // Simultaneous push and pop at level 1
        bus.m_ready = 1'b0;
        clear_mon();
        spi_q = '{8'h44, 8'h77};
        start_burst(8'd2);
        n = 0;
        @(negedge clk);
        while (!(bus.spi_rd_en && bus.fifo_level == 4'd1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("pp_reach", 32'(bus.fifo_level), 32'd1);
        tick(1);
        tick(1);
        bus.m_ready = 1'b1;
        @(negedge clk);
        check_eq("pp_align", 32'(bus.spi_rd_done), 32'd1);
        tick(1);
        bus.m_ready = 1'b0;
        @(negedge clk);
        check_eq("pp_level", 32'(bus.fifo_level), 32'd1);
        check_eq("pp_m_data", 32'(bus.m_data), 32'h77);
        tick(1);
        bus.m_ready = 1'b1;
        wait_done("pp_done_seen");
        tick(3);
        check_eq("pp_pops", 32'(pop_cnt), 32'd2);

        // Reset mid-byte with two bytes stored
        bus.m_ready = 1'b0;
        clear_mon();
        spi_q = '{8'h11, 8'h22, 8'h33};
        start_burst(8'd3);
        n = 0;
        @(negedge clk);
        while (!(bus.spi_rd_en && bus.fifo_level == 4'd2) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("mr_reach", 32'(bus.fifo_level), 32'd2);
        rst = 1'b1;
        spi_q.delete();
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr_rd_en", 32'(bus.spi_rd_en), 32'd0);
        check_eq("mr_level", 32'(bus.fifo_level), 32'd0);
        check_eq("mr_valid", 32'(bus.m_valid), 32'd0);
        check_eq("mr_busy", 32'(bus.busy), 32'd0);
        check_eq("mr_m_data", 32'(bus.m_data), 32'd0);
        tick(1);
        bus.m_ready = 1'b1;
        clear_mon();
        spi_q = '{8'h5A};
        start_burst(8'd1);
        wait_done("mr_after_done");
        tick(3);
        check_eq("mr_after_pops", 32'(pop_cnt), 32'd1);
        check_eq("mr_after_err", 32'(bus.err), 32'd0);

        // Spurious spi_rd_done in IDLE
        spur_req = 1'b1;
        tick(4);
        @(negedge clk);
        check_eq("spur_err", 32'(bus.err), 32'd1);
        check_eq("spur_level", 32'(bus.fifo_level), 32'd0);
        tick(1);
        clear_mon();
        spi_q = '{8'h5C};
        start_burst(8'd1);
        wait_done("spur_burst_done");
        tick(3);
        check_eq("spur_burst_pops", 32'(pop_cnt), 32'd1);
        @(negedge clk);
        check_eq("spur_err_sticky", 32'(bus.err), 32'd1);
        tick(1);
        do_reset();
        @(negedge clk);
        check_eq("spur_err_cleared", 32'(bus.err), 32'd0);
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
